// File: rtl/seg_scan_decoder_if.sv
// Frame output bus of seg_scan_decoder: recovered BCD digits, blank mask and a valid/ready handshake.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output bcd_out, output blank_mask, output out_valid, input out_ready);
    modport slave  (input bcd_out, input blank_mask, input out_valid, output out_ready);
endinterface

// File: rtl/seg_scan_decoder.sv
// Sniffs a multiplexed active-low seven-segment bus, debounces each digit slot and
// publishes whole frames of recovered BCD digits over a valid/ready interface.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            segments,
    input  logic [NUM_DIGITS-1:0] digit_sel,
    input  logic                  clear_flags,
    output logic                  illegal_flag,
    output logic                  overflow_flag,
    seg_scan_decoder_if.master    frame
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HOLD} state_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       illegal;
    } digit_t;

    function automatic digit_t decode(input logic [6:0] pat);
        digit_t d;
        d = '{nibble: 4'hE, blank: 1'b0, illegal: 1'b0};
        case (pat)
            7'b1000000: d.nibble = 4'd0;
            7'b1111001: d.nibble = 4'd1;
            7'b0100100: d.nibble = 4'd2;
            7'b0110000: d.nibble = 4'd3;
            7'b0011001: d.nibble = 4'd4;
            7'b0010010: d.nibble = 4'd5;
            7'b0000010: d.nibble = 4'd6;
            7'b1111000: d.nibble = 4'd7;
            7'b0000000: d.nibble = 4'd8;
            7'b0010000: d.nibble = 4'd9;
            7'b1111111: begin d.nibble = 4'hF; d.blank = 1'b1; end
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [6:0]            seg_meta, seg_sync, ld_seg;
    logic [NUM_DIGITS-1:0] sel_meta, sel_sync, ld_sel;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  load, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= '0;
            seg_sync <= '0;
            sel_meta <= '0;
            sel_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            seg_meta <= segments;
            seg_sync <= seg_meta;
            sel_meta <= digit_sel;
            sel_sync <= sel_meta;
        end
    end

    logic sel_valid, same;
    assign sel_valid = $onehot(~sel_sync);
    assign same      = (seg_sync == ld_seg) && (sel_sync == ld_sel);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            S_WAIT: if (sel_valid) begin
                load    = 1'b1;
                cnt_n   = CW'(1);
                state_n = S_COUNT;
            end
            S_COUNT: if (same) begin
                if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    cnt_n   = CW'(STABLE_CYCLES);
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end else if (sel_valid) begin
                load  = 1'b1;
                cnt_n = CW'(1);
            end else begin
                state_n = S_WAIT;
            end
            S_HOLD: if (!same) begin
                if (sel_valid) begin
                    load    = 1'b1;
                    cnt_n   = CW'(1);
                    state_n = S_COUNT;
                end else begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_WAIT;
            cnt    <= '0;
            ld_seg <= '0;
            ld_sel <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                ld_seg <= seg_sync;
                ld_sel <= sel_sync;
            end
        end
    end

    // Staging collects captured digits; the mask tracks which slots belong to the current frame.
    digit_t                  cap;
    logic [NUM_DIGITS-1:0]   cap_bit, mask, stage_blank;
    logic [4*NUM_DIGITS-1:0] stage_bcd;
    logic                    frame_done;

    assign cap        = decode(ld_seg);
    assign cap_bit    = ~ld_sel;
    assign frame_done = &mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= '0;
            stage_bcd   <= '0;
            stage_blank <= '0;
        end else begin
            if (frame_done)
                mask <= '0;
            else if (capture)
                mask <= (|(mask & cap_bit)) ? cap_bit : (mask | cap_bit);
            if (capture) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (cap_bit[k]) begin
                        stage_bcd[4*k +: 4] <= cap.nibble;
                        stage_blank[k]      <= cap.blank;
                    end
                end
            end
        end
    end

    logic overflow_set;
    assign overflow_set = frame_done && frame.out_valid && !frame.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame.bcd_out    <= '0;
            frame.blank_mask <= '0;
            frame.out_valid  <= 1'b0;
            illegal_flag     <= 1'b0;
            overflow_flag    <= 1'b0;
        end else begin
            // A same-cycle accept frees the slot, so the completing frame loads behind it.
            if (frame_done && !overflow_set) begin
                frame.bcd_out    <= stage_bcd;
                frame.blank_mask <= stage_blank;
                frame.out_valid  <= 1'b1;
            end else if (frame.out_valid && frame.out_ready) begin
                frame.out_valid  <= 1'b0;
            end
            illegal_flag  <= (illegal_flag & ~clear_flags) | (capture & cap.illegal);
            overflow_flag <= (overflow_flag & ~clear_flags) | overflow_set;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives a scanned display, predicts frames into a
// scoreboard queue and compares them with immediate assertions as the DUT publishes.
module tb_seg_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 8;
    localparam logic [6:0] BLANK_PAT = 7'b1111111;
    localparam logic [6:0] ILL_PAT   = 7'b0101010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    segments;
    logic [ND-1:0] digit_sel;
    logic          clear_flags;
    logic          illegal_flag, overflow_flag;

    seg_scan_decoder_if #(.NUM_DIGITS(ND)) frame ();

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .segments      (segments),
        .digit_sel     (digit_sel),
        .clear_flags   (clear_flags),
        .illegal_flag  (illegal_flag),
        .overflow_flag (overflow_flag),
        .frame         (frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     failures = 0;
    int     first_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK_PAT;
        endcase
    endfunction

    // Light slot k with pat for hold cycles, then 2 cycles of inter-digit blanking.
    task automatic show(input int k, input logic [6:0] pat, input int hold);
        segments    = pat;
        digit_sel   = ~(ND'(1) << k);
        first_valid = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (frame.out_valid && first_valid == 0) first_valid = i;
        end
        segments  = BLANK_PAT;
        digit_sel = '1;
        repeat (2) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3);
        show(0, p0, 12);
        show(1, p1, 12);
        show(2, p2, 12);
        show(3, p3, 12);
    endtask

    task automatic expect_frame(input logic [15:0] bcd, input logic [3:0] blank);
        frame_t e;
        e.bcd   = bcd;
        e.blank = blank;
        sb.push_back(e);
    endtask

    task automatic check_frame(input string tag);
        frame_t e;
        int     n = 0;
        while (!frame.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, frame.out_valid, 1);
        check({tag, "_sb_pending"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_bcd"}, frame.bcd_out, e.bcd);
            check({tag, "_blank"}, frame.blank_mask, e.blank);
        end
    endtask

    task automatic accept(input string tag);
        frame.out_ready = 1'b1;
        @(negedge clk);
        frame.out_ready = 1'b0;
        check(tag, frame.out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        segments        = BLANK_PAT;
        digit_sel       = '1;
        clear_flags     = 1'b0;
        frame.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", frame.bcd_out, 0);
        check("rst_blank", frame.blank_mask, 0);
        check("rst_valid", frame.out_valid, 0);
        check("rst_illegal", illegal_flag, 0);
        check("rst_overflow", overflow_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean scan "1234", with first-capture-to-valid latency measured on digit 3.
        expect_frame(16'h4321, 4'b0000);
        show(0, seg_of(1), 12);
        show(1, seg_of(2), 12);
        show(2, seg_of(3), 12);
        check("clean_early_valid", frame.out_valid, 0);
        show(3, seg_of(4), 12);
        check("clean_latency", first_valid, 11);
        check_frame("clean");
        accept("clean_accept");

        // Glitch: "5" for only 7 cycles on digit 1, then "9".
        expect_frame(16'h4391, 4'b0000);
        show(0, seg_of(1), 12);
        segments  = seg_of(5);
        digit_sel = ~ND'(2);
        repeat (7) @(negedge clk);
        show(1, seg_of(9), 12);
        show(2, seg_of(3), 12);
        show(3, seg_of(4), 12);
        check_frame("glitch");
        accept("glitch_accept");

        // Repeat digit: 0,1,0,1,2,3 restarts the frame at the second digit 0.
        expect_frame(16'h0765, 4'b0000);
        show(0, seg_of(1), 12);
        show(1, seg_of(2), 12);
        show(0, seg_of(5), 12);
        show(1, seg_of(6), 12);
        show(2, seg_of(7), 12);
        check("repeat_early_valid", frame.out_valid, 0);
        show(3, seg_of(0), 12);
        check_frame("repeat");
        accept("repeat_accept");

        // Backpressure: second frame is dropped while the first is still pending.
        expect_frame(16'h4321, 4'b0000);
        scan(seg_of(1), seg_of(2), seg_of(3), seg_of(4));
        check("bp_overflow_before", overflow_flag, 0);
        scan(seg_of(5), seg_of(6), seg_of(7), seg_of(8));
        check_frame("bp");
        check("bp_overflow", overflow_flag, 1);
        accept("bp_accept");
        check("bp_overflow_sticky", overflow_flag, 1);

        // Blank and illegal patterns; frame is left pending for the reset test.
        check("ill_before", illegal_flag, 0);
        expect_frame(16'hEF87, 4'b0100);
        scan(seg_of(7), seg_of(8), BLANK_PAT, ILL_PAT);
        check_frame("blank_ill");
        check("ill_set", illegal_flag, 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ill_cleared", illegal_flag, 0);
        check("ovf_cleared", overflow_flag, 0);

        // Reset mid-COUNT: digit 0 stable for 5 samples, then reset.
        segments  = seg_of(3);
        digit_sel = ~ND'(1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", frame.out_valid, 0);
        check("midrst_bcd", frame.bcd_out, 0);
        check("midrst_blank", frame.blank_mask, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        segments  = BLANK_PAT;
        digit_sel = '1;
        repeat (2) @(negedge clk);
        show(1, seg_of(6), 12);
        show(2, seg_of(1), 12);
        show(3, seg_of(9), 12);
        check("midrst_no_capture", frame.out_valid, 0);
        expect_frame(16'h9163, 4'b0000);
        show(0, seg_of(3), 12);
        check("midrst_latency", first_valid, 11);
        check_frame("midrst");
        accept("midrst_accept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
